// File: rtl/rope_fire_ctrl.sv
// rope_fire_ctrl: turns the fire key into one deploy/flight/cooldown shot.
// Build option: ROPE_AUTOFIRE_EN (a held key refires after cooldown).
module rope_fire_ctrl #(
  parameter int ROPE_X_OFFSET     = 16,
  parameter int COOLDOWN_FRAMES   = 8,
  parameter int MAX_FLIGHT_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        fireKey,
  input  logic [10:0] playerX,
  input  logic        movingUp,
  input  logic        ropeHit,
  output logic        deploy,
  output logic [10:0] ropeX,
  output logic        ropeActive,
  output logic        hitPulse,
  output logic [7:0]  shotCount
);

  typedef enum logic [1:0] {
    IDLE,
    DEPLOY,
    FLYING,
    COOLDOWN
  } state_t;

  localparam logic [11:0] OFF12  = 12'(ROPE_X_OFFSET);
  localparam logic [11:0] XMAX12 = 12'd639;
  localparam logic [7:0]  COOL8  = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0]  MAX8   = 8'(MAX_FLIGHT_FRAMES);

  state_t      state, state_n;
  logic        fire_d;
  logic        fire_edge;
  logic        fire_req;
  logic [7:0]  flight, flight_n;
  logic [7:0]  cool, cool_n;
  logic        hit_seen, hit_seen_n;
  logic        hit_n;
  logic [10:0] rope_x_n;
  logic [7:0]  shot_n;
  logic [11:0] sum12;
  logic [10:0] sat_x;

  assign fire_edge = fireKey & ~fire_d;

`ifdef ROPE_AUTOFIRE_EN
  assign fire_req = fireKey | fire_edge;
`else
  assign fire_req = fire_edge;
`endif

  // Rope column: clamp to the last visible pixel column.
  assign sum12 = {1'b0, playerX} + OFF12;
  assign sat_x = (sum12 > XMAX12) ? XMAX12[10:0] : sum12[10:0];

  // Next-state and next-register values for the shot sequence.
  always_comb begin
    state_n    = state;
    rope_x_n   = ropeX;
    shot_n     = shotCount;
    flight_n   = flight;
    cool_n     = cool;
    hit_seen_n = hit_seen;
    hit_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire_req && !movingUp) begin
          state_n    = DEPLOY;
          rope_x_n   = sat_x;
          shot_n     = shotCount + 8'd1;
          flight_n   = 8'd0;
          hit_seen_n = 1'b0;
        end
      end
      DEPLOY: begin
        if (startOfFrame) state_n = FLYING;
      end
      FLYING: begin
        if (startOfFrame) flight_n = flight + 8'd1;
        if (ropeHit && !hit_seen) begin
          hit_n      = 1'b1;
          hit_seen_n = 1'b1;
        end
        if ((!movingUp && !startOfFrame) ||
            (flight_n == MAX8)) begin
          state_n = COOLDOWN;
          cool_n  = COOL8;
        end
      end
      COOLDOWN: begin
        if (cool == 8'd0) state_n = IDLE;
        else if (startOfFrame) cool_n = cool - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fire_d     <= 1'b0;
      flight     <= 8'd0;
      cool       <= 8'd0;
      hit_seen   <= 1'b0;
      deploy     <= 1'b0;
      ropeX      <= 11'd0;
      ropeActive <= 1'b0;
      hitPulse   <= 1'b0;
      shotCount  <= 8'd0;
    end else begin
      state      <= state_n;
      fire_d     <= fireKey;
      flight     <= flight_n;
      cool       <= cool_n;
      hit_seen   <= hit_seen_n;
      deploy     <= (state_n == DEPLOY);
      ropeX      <= rope_x_n;
      ropeActive <= (state_n == DEPLOY) ||
                    (state_n == FLYING);
      hitPulse   <= hit_n;
      shotCount  <= shot_n;
    end
  end

endmodule

// File: tb/tb_rope_fire_ctrl.sv
// tb_rope_fire_ctrl: scenario tasks with randomized player positions
// and hit timing, checked against expectations derived from the rules.
module tb_rope_fire_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sof = 1'b0;
  logic        fk = 1'b0;
  logic [10:0] px = 11'd0;
  logic        mu = 1'b0;
  logic        hit = 1'b0;
  logic        deploy;
  logic [10:0] rope_x;
  logic        rope_active;
  logic        hit_pulse;
  logic [7:0]  shot_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  exp_shots = 8'd0;

  rope_fire_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof),
    .fireKey      (fk),
    .playerX      (px),
    .movingUp     (mu),
    .ropeHit      (hit),
    .deploy       (deploy),
    .ropeX        (rope_x),
    .ropeActive   (rope_active),
    .hitPulse     (hit_pulse),
    .shotCount    (shot_count)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] exp_col(input int x);
    int s;
    s = x + 16;
    return (s > 639) ? 11'd639 : 11'(s);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 4-cycle frame with the pulse in its first cycle
  task automatic frame();
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic press();
    fk = 1'b1;
    cyc();
    fk = 1'b0;
  endtask

  // DEPLOY -> FLYING; the mover raises movingUp on that frame
  task automatic launch();
    sof = 1'b1;
    mu  = 1'b1;
    cyc();
    sof = 1'b0;
  endtask

  // rope returns, then enough frames to finish cooldown
  task automatic land();
    mu = 1'b0;
    cyc();
    repeat (9) frame();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fk = 1'b1;
    px = 11'd300;
    cyc();
    cyc();
    fk = 1'b0;
    n_cmp += 5;
    if (deploy !== 1'b0) begin
      n_bad++; $display("FAIL rst_deploy got %b want 0", deploy);
    end
    if (rope_x !== 11'd0) begin
      n_bad++; $display("FAIL rst_ropex got %0d want 0", rope_x);
    end
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL rst_active got %b want 0", rope_active);
    end
    if (hit_pulse !== 1'b0) begin
      n_bad++; $display("FAIL rst_hit got %b want 0", hit_pulse);
    end
    if (shot_count !== 8'd0) begin
      n_bad++; $display("FAIL rst_shots got %0d want 0", shot_count);
    end
    reset = 1'b0;
    exp_shots = 8'd0;
    cyc();
  endtask

  task automatic test_basic();
    px = 11'd100;
    press();
    exp_shots++;
    n_cmp += 4;
    if (deploy !== 1'b1) begin
      n_bad++; $display("FAIL basic_deploy got %b want 1", deploy);
    end
    if (rope_x !== 11'd116) begin
      n_bad++; $display("FAIL basic_ropex got %0d want 116", rope_x);
    end
    if (shot_count !== exp_shots) begin
      n_bad++;
      $display("FAIL basic_shots got %0d want %0d", shot_count, exp_shots);
    end
    if (rope_active !== 1'b1) begin
      n_bad++; $display("FAIL basic_active got %b want 1", rope_active);
    end
    repeat (2) cyc();
    n_cmp++;
    if (deploy !== 1'b1) begin
      n_bad++; $display("FAIL basic_hold got %b want 1", deploy);
    end
    launch();
    n_cmp += 2;
    if (deploy !== 1'b0) begin
      n_bad++; $display("FAIL basic_fall got %b want 0", deploy);
    end
    if (rope_active !== 1'b1) begin
      n_bad++; $display("FAIL basic_fly got %b want 1", rope_active);
    end
    repeat (3) cyc();
    mu = 1'b0;
    cyc();
    n_cmp++;
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL basic_return got %b want 0", rope_active);
    end
  endtask

  task automatic test_cooldown();
    repeat (5) frame();
    press();
    n_cmp += 2;
    if (deploy !== 1'b0) begin
      n_bad++; $display("FAIL cool_early got %b want 0", deploy);
    end
    if (shot_count !== exp_shots) begin
      n_bad++;
      $display("FAIL cool_early_shots got %0d want %0d", shot_count, exp_shots);
    end
    repeat (4) frame();
    press();
    exp_shots++;
    n_cmp += 2;
    if (deploy !== 1'b1) begin
      n_bad++; $display("FAIL cool_late got %b want 1", deploy);
    end
    if (shot_count !== exp_shots) begin
      n_bad++;
      $display("FAIL cool_late_shots got %0d want %0d", shot_count, exp_shots);
    end
    launch();
    land();
  endtask

  task automatic test_saturation();
    int xs[9];
    logic [10:0] want;
    xs = '{630, 623, 624, 2047, 0, 0, 0, 0, 0};
    for (int k = 5; k < 9; k++) xs[k] = int'($urandom_range(0, 2047));
    for (int k = 0; k < 9; k++) begin
      px = 11'(xs[k]);
      want = exp_col(xs[k]);
      press();
      exp_shots++;
      px = 11'($urandom);
      launch();
      n_cmp += 3;
      if (rope_x !== want) begin
        n_bad++;
        $display("FAIL sat_ropex x=%0d got %0d want %0d", xs[k], rope_x, want);
      end
      if (shot_count !== exp_shots) begin
        n_bad++;
        $display("FAIL sat_shots got %0d want %0d", shot_count, exp_shots);
      end
      land();
      if (rope_x !== want) begin
        n_bad++;
        $display("FAIL sat_hold x=%0d got %0d want %0d", xs[k], rope_x, want);
      end
    end
  endtask

  task automatic test_hits();
    logic hm[32];
    int w, first, p;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) hm[i] = 1'b0;
      w = int'($urandom_range(8, 20));
      first = int'($urandom_range(0, w - 4));
      hm[first] = 1'b1;
      for (int j = 0; j < 2; j++) begin
        p = int'($urandom_range(first + 1, w - 1));
        hm[p] = 1'b1;
      end
      px = 11'($urandom);
      press();
      exp_shots++;
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      n_cmp++;
      if (hit_pulse !== 1'b0) begin
        n_bad++; $display("FAIL hit_in_deploy got %b want 0", hit_pulse);
      end
      launch();
      for (int i = 0; i < w; i++) begin
        hit = hm[i];
        cyc();
        n_cmp++;
        if (hit_pulse !== (i == first)) begin
          n_bad++;
          $display("FAIL hit_pulse cyc=%0d got %b want %b",
                   i, hit_pulse, (i == first));
        end
      end
      hit = 1'b0;
      mu = 1'b0;
      cyc();
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      n_cmp++;
      if (hit_pulse !== 1'b0) begin
        n_bad++; $display("FAIL hit_in_cool got %b want 0", hit_pulse);
      end
      repeat (9) frame();
    end
  endtask

  task automatic test_hit_on_exit();
    press();
    exp_shots++;
    launch();
    repeat (2) cyc();
    hit = 1'b1;
    mu = 1'b0;
    cyc();
    hit = 1'b0;
    n_cmp += 3;
    if (hit_pulse !== 1'b1) begin
      n_bad++; $display("FAIL exit_hit got %b want 1", hit_pulse);
    end
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL exit_active got %b want 0", rope_active);
    end
    cyc();
    if (hit_pulse !== 1'b0) begin
      n_bad++; $display("FAIL exit_width got %b want 0", hit_pulse);
    end
    repeat (9) frame();
  endtask

  task automatic test_stale();
    mu = 1'b1;
    press();
    n_cmp += 3;
    if (deploy !== 1'b0) begin
      n_bad++; $display("FAIL stale_deploy got %b want 0", deploy);
    end
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL stale_active got %b want 0", rope_active);
    end
    if (shot_count !== exp_shots) begin
      n_bad++;
      $display("FAIL stale_shots got %0d want %0d", shot_count, exp_shots);
    end
    mu = 1'b0;
    cyc();
  endtask

  task automatic test_watchdog();
    press();
    exp_shots++;
    launch();
    repeat (63) frame();
    n_cmp++;
    if (rope_active !== 1'b1) begin
      n_bad++; $display("FAIL wd_early got %b want 1", rope_active);
    end
    sof = 1'b1;
    cyc();
    sof = 1'b0;
    n_cmp++;
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL wd_expire got %b want 0", rope_active);
    end
    mu = 1'b0;
    repeat (9) frame();
  endtask

  task automatic test_reset_mid();
    px = 11'd200;
    press();
    n_cmp++;
    if (deploy !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre got %b want 1", deploy);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_shots = 8'd0;
    n_cmp += 4;
    if (deploy !== 1'b0) begin
      n_bad++; $display("FAIL mid_deploy got %b want 0", deploy);
    end
    if (rope_active !== 1'b0) begin
      n_bad++; $display("FAIL mid_active got %b want 0", rope_active);
    end
    if (rope_x !== 11'd0) begin
      n_bad++; $display("FAIL mid_ropex got %0d want 0", rope_x);
    end
    if (shot_count !== exp_shots) begin
      n_bad++; $display("FAIL mid_shots got %0d want 0", shot_count);
    end
    cyc();
  endtask

  task automatic test_autofire();
    fk = 1'b1;
    cyc();
    exp_shots++;
    launch();
    repeat (2) cyc();
    mu = 1'b0;
    cyc();
    repeat (9) frame();
`ifdef ROPE_AUTOFIRE_EN
    exp_shots++;
`endif
    n_cmp++;
    if (shot_count !== exp_shots) begin
      n_bad++;
      $display("FAIL auto_shots got %0d want %0d", shot_count, exp_shots);
    end
    fk = 1'b0;
    repeat (10) frame();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cooldown();
    test_saturation();
    test_hits();
    test_hit_on_exit();
    test_stale();
    test_watchdog();
    test_reset_mid();
    test_autofire();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
